// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master Wishbone arbiter with M0 anti-starvation and no-ack timeout
//
// Ports:
//   wb_clk_i, wb_rst_n          clock, asynchronous active-low reset
//   m0_* / m1_*                 master-side Wishbone (adr, dat, sel, we, cyc, stb in;
//                               gnt, ack, err out)
//   m_dat_o                     slave read data broadcast to both masters
//   s_adr_o .. s_stb_o          slave-side Wishbone driven from the current owner
//   s_ack_i, s_dat_i            OR of slave acks, muxed slave read data
module wb_arb2 #(
   parameter int BURST_MAX = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n,
   input  logic [15:0] m0_adr_i,
   input  logic [15:0] m0_dat_i,
   input  logic [1:0]  m0_sel_i,
   input  logic        m0_we_i,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   output logic        m0_gnt_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic [15:0] m1_adr_i,
   input  logic [15:0] m1_dat_i,
   input  logic [1:0]  m1_sel_i,
   input  logic        m1_we_i,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   output logic        m1_gnt_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [15:0] m_dat_o,
   output logic [15:0] s_adr_o,
   output logic [15:0] s_dat_o,
   output logic [1:0]  s_sel_o,
   output logic        s_we_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   input  logic        s_ack_i,
   input  logic [15:0] s_dat_i
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0]    B_MAX  = 8'(BURST_MAX);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

   state_t        state, state_nx;
   logic [7:0]    scnt, scnt_nx;
   logic [TW-1:0] tcnt, tcnt_nx;
   logic          owner, owner_nx;   // last granted master, selects who gets err
   logic          own_cyc, own_stb;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         state <= IDLE;
         scnt  <= '0;
         tcnt  <= '0;
         owner <= 1'b0;
      end else begin
         state <= state_nx;
         scnt  <= scnt_nx;
         tcnt  <= tcnt_nx;
         owner <= owner_nx;
      end
   end

   assign own_cyc = (state == GNT1) ? m1_cyc_i : m0_cyc_i;
   assign own_stb = (state == GNT1) ? m1_stb_i : m0_stb_i;

   always_comb begin
      state_nx = state;
      scnt_nx  = scnt;
      tcnt_nx  = '0;               // cleared whenever not actively waiting on an ack
      owner_nx = owner;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) begin
               // M1 is favoured until it has taken BURST_MAX grants over a waiting M0
               if (scnt >= B_MAX) begin
                  state_nx = GNT0;
                  owner_nx = 1'b0;
                  scnt_nx  = '0;
               end else begin
                  state_nx = GNT1;
                  owner_nx = 1'b1;
                  scnt_nx  = scnt + 8'd1;
               end
            end else if (m0_cyc_i) begin
               state_nx = GNT0;
               owner_nx = 1'b0;
               scnt_nx  = '0;
            end else if (m1_cyc_i) begin
               state_nx = GNT1;
               owner_nx = 1'b1;
            end
         end
         GNT0, GNT1: begin
            if (!own_cyc) begin
               state_nx = IDLE;
            end else if (own_stb && !s_ack_i) begin
               // an ack on the final clock takes this branch's else path, so ack wins
               if (tcnt == T_LAST) state_nx = ERR;
               else                tcnt_nx  = tcnt + 1'b1;
            end
         end
         ERR: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_ack_o = 1'b0;
      m1_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_err_o = 1'b0;
      case (state)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            m0_ack_o = s_ack_i;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            m1_ack_o = s_ack_i;
         end
         ERR: begin
            m0_err_o = !owner;
            m1_err_o = owner;
         end
         default: ;
      endcase
   end

   assign m0_gnt_o = (state == GNT0);
   assign m1_gnt_o = (state == GNT1);
   assign m_dat_o  = s_dat_i;

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - self-checking bench for wb_arb2
module tb_wb_arb2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_in;
   logic [1:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
   logic        m0_gnt, m0_ack, m0_err, m1_gnt, m1_ack, m1_err;
   logic [15:0] m_dat, s_adr, s_dat;
   logic [1:0]  s_sel;
   logic        s_we, s_cyc, s_stb, s_ack;
   logic        auto_ack, man_ack;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] sb_q[$];
   int          own_q[$];

   assign s_ack = auto_ack ? s_stb : man_ack;

   always #5 clk = ~clk;

   wb_arb2 #(.BURST_MAX(8), .TIMEOUT(64)) dut (
      .wb_clk_i(clk), .wb_rst_n(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
      .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_gnt_o(m0_gnt), .m0_ack_o(m0_ack),
      .m0_err_o(m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
      .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_gnt_o(m1_gnt), .m1_ack_o(m1_ack),
      .m1_err_o(m1_err),
      .m_dat_o(m_dat), .s_adr_o(s_adr), .s_dat_o(s_dat), .s_sel_o(s_sel),
      .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_ack_i(s_ack),
      .s_dat_i(s_dat_in)
   );

   task automatic step;
      @(negedge clk);
   endtask

   task automatic idle_inputs;
      m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
      m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
      s_dat_in = '0; auto_ack = 0; man_ack = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst_n = 0;
      step(); step();
      rst_n = 1;
      step();
   endtask

   task automatic test_reset;
      idle_inputs();
      rst_n = 0;
      step(); step();
      n_vec++;
      if ({m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_master_outs got=%b exp=000000",
                  {m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err});
      end
      n_vec++;
      if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat} !== 37'b0) begin
         n_err++;
         $display("FAIL reset_slave_outs got=%h exp=0", {s_cyc, s_stb, s_we, s_sel, s_adr, s_dat});
      end
      rst_n = 1;
      step();
   endtask

   task automatic test_single_read;
      logic [15:0] exp_d;
      do_reset();
      m0_adr = 16'o177560; m0_sel = 2'b11; m0_we = 0; m0_cyc = 1; m0_stb = 1;
      sb_q.push_back(16'hBEEF);
      step();
      n_vec++;
      if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
         n_err++; $display("FAIL read_gnt_latency got=%b%b exp=10", m0_gnt, m1_gnt);
      end
      n_vec++;
      if (s_adr !== 16'o177560 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_sel !== 2'b11 || s_we !== 1'b0) begin
         n_err++; $display("FAIL read_slave_mux got adr=%o cyc=%b stb=%b exp adr=177560 cyc=1 stb=1", s_adr, s_cyc, s_stb);
      end
      step();
      n_vec++;
      if (m0_ack !== 1'b0) begin
         n_err++; $display("FAIL read_early_ack got=%b exp=0", m0_ack);
      end
      step();
      man_ack = 1; s_dat_in = 16'hBEEF;
      #1;
      exp_d = sb_q.pop_front();
      n_vec++;
      if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m_dat !== exp_d) begin
         n_err++; $display("FAIL read_ack got ack0=%b ack1=%b dat=%h exp 1 0 %h", m0_ack, m1_ack, m_dat, exp_d);
      end
      step();
      man_ack = 0; m0_cyc = 0; m0_stb = 0;
      #1;
      n_vec++;
      if (m0_ack !== 1'b0) begin
         n_err++; $display("FAIL read_ack_pulse got=%b exp=0", m0_ack);
      end
      step();
      n_vec++;
      if (m0_gnt !== 1'b0 || s_cyc !== 1'b0) begin
         n_err++; $display("FAIL read_release got gnt=%b cyc=%b exp 0 0", m0_gnt, s_cyc);
      end
      man_ack = 1;
      #1;
      n_vec++;
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
         n_err++; $display("FAIL idle_ack_ignored got=%b%b exp=00", m0_ack, m1_ack);
      end
      man_ack = 0;
   endtask

   task automatic test_starvation;
      int ph0, ph1, idle_run, got, exp_o, obs_o;
      logic g0, g1, a0, a1, p0, p1;
      do_reset();
      own_q.delete();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 8; k++) own_q.push_back(1);
         own_q.push_back(0);
      end
      auto_ack = 1;
      m0_adr = 16'h0100; m1_adr = 16'h0200;
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      ph0 = 0; ph1 = 0; idle_run = 1; got = 0; p0 = 0; p1 = 0;
      for (int c = 0; c < 400 && got < 18; c++) begin
         step();
         g0 = m0_gnt; g1 = m1_gnt; a0 = m0_ack; a1 = m1_ack;
         if ((g0 && !p0) || (g1 && !p1)) begin
            exp_o = own_q.pop_front();
            obs_o = g1 ? 1 : 0;
            got++;
            n_vec++;
            if (obs_o !== exp_o || idle_run !== 1) begin
               n_err++;
               $display("FAIL starve_grant_%0d got owner=%0d idle=%0d exp owner=%0d idle=1", got, obs_o, idle_run, exp_o);
            end
         end
         if (!g0 && !g1) idle_run++; else idle_run = 0;
         if (ph0 == 2) begin m0_cyc = 1; m0_stb = 1; ph0 = 0; end
         else if (ph0 == 1) begin m0_cyc = 0; m0_stb = 0; ph0 = 2; end
         else if (a0) ph0 = 1;
         if (ph1 == 2) begin m1_cyc = 1; m1_stb = 1; ph1 = 0; end
         else if (ph1 == 1) begin m1_cyc = 0; m1_stb = 0; ph1 = 2; end
         else if (a1) ph1 = 1;
         p0 = g0; p1 = g1;
      end
      n_vec++;
      if (got !== 18) begin
         n_err++; $display("FAIL starve_timeout got grants=%0d exp=18", got);
      end
      idle_inputs();
      step(); step();
   endtask

   task automatic test_burst_hold;
      logic [15:0] exp_a;
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0001;
      m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 16'h1000;
      step();
      for (int b = 0; b < 4; b++) begin
         m1_adr = 16'h1000 + 16'(b); m1_dat = 16'hA000 + 16'(b);
         sb_q.push_back(16'h1000 + 16'(b));
         man_ack = 0;
         step();
         man_ack = 1;
         #1;
         exp_a = sb_q.pop_front();
         n_vec++;
         if (s_adr !== exp_a || m1_ack !== 1'b1 || m0_ack !== 1'b0 || m0_gnt !== 1'b0 || s_we !== 1'b1) begin
            n_err++;
            $display("FAIL burst_beat_%0d got adr=%h ack1=%b ack0=%b gnt0=%b exp adr=%h 1 0 0", b, s_adr, m1_ack, m0_ack, m0_gnt, exp_a);
         end
         step();
      end
      man_ack = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
      step();
      n_vec++;
      if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || s_cyc !== 1'b0) begin
         n_err++; $display("FAIL burst_dead_clock got gnt=%b%b cyc=%b exp 00 0", m0_gnt, m1_gnt, s_cyc);
      end
      step();
      n_vec++;
      if (m0_gnt !== 1'b1 || s_adr !== 16'h0001) begin
         n_err++; $display("FAIL burst_handover got gnt0=%b adr=%h exp 1 0001", m0_gnt, s_adr);
      end
      idle_inputs();
      step(); step();
   endtask

   task automatic test_timeout;
      int stb_clks;
      logic seen_err, seen_ack;
      do_reset();
      m0_adr = 16'o177776; m0_cyc = 1; m0_stb = 1;
      stb_clks = 0; seen_err = 0; seen_ack = 0;
      for (int c = 0; c < 200 && !seen_err; c++) begin
         step();
         if (m0_ack) seen_ack = 1;
         if (m0_err) begin
            seen_err = 1;
            n_vec++;
            if (s_cyc !== 1'b0 || s_stb !== 1'b0 || m0_gnt !== 1'b0 || m1_err !== 1'b0) begin
               n_err++; $display("FAIL timeout_err_state got cyc=%b stb=%b gnt=%b err1=%b exp 0 0 0 0", s_cyc, s_stb, m0_gnt, m1_err);
            end
         end else if (m0_gnt && s_stb) begin
            stb_clks++;
         end
      end
      n_vec++;
      if (!seen_err || stb_clks !== 64 || seen_ack) begin
         n_err++; $display("FAIL timeout_count got err=%b clks=%0d ack=%b exp 1 64 0", seen_err, stb_clks, seen_ack);
      end
      m0_cyc = 0; m0_stb = 0;
      step();
      n_vec++;
      if (m0_err !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
         n_err++; $display("FAIL timeout_back_idle got err=%b gnt=%b%b exp 0 00", m0_err, m0_gnt, m1_gnt);
      end
   endtask

   task automatic test_ack_vs_timeout;
      int gclks;
      logic seen_err;
      do_reset();
      m0_adr = 16'o177560; m0_cyc = 1; m0_stb = 1;
      gclks = 0; seen_err = 0;
      for (int c = 0; c < 200 && gclks < 64; c++) begin
         step();
         if (m0_err) seen_err = 1;
         if (m0_gnt) gclks++;
      end
      man_ack = 1;
      #1;
      n_vec++;
      if (gclks !== 64 || m0_ack !== 1'b1 || m0_err !== 1'b0) begin
         n_err++; $display("FAIL ackwin_ack got clks=%0d ack=%b err=%b exp 64 1 0", gclks, m0_ack, m0_err);
      end
      step();
      man_ack = 0;
      #1;
      n_vec++;
      if (m0_err !== 1'b0 || m0_gnt !== 1'b1 || seen_err) begin
         n_err++; $display("FAIL ackwin_no_err got err=%b gnt=%b early=%b exp 0 1 0", m0_err, m0_gnt, seen_err);
      end
      m0_cyc = 0; m0_stb = 0;
      step(); step();
   endtask

   task automatic test_reset_mid_burst;
      do_reset();
      m0_cyc = 1; m0_stb = 1;
      m1_cyc = 1; m1_stb = 1; m1_adr = 16'h2000;
      step();
      n_vec++;
      if (m1_gnt !== 1'b1 || dut.scnt !== 8'd1) begin
         n_err++; $display("FAIL rst_pre_grant got gnt1=%b scnt=%0d exp 1 1", m1_gnt, dut.scnt);
      end
      man_ack = 1;
      step();
      #2;
      rst_n = 0;
      #1;
      n_vec++;
      if ({s_cyc, s_stb, m1_gnt, m0_gnt, m0_ack, m1_ack, m0_err, m1_err} !== 8'b0) begin
         n_err++;
         $display("FAIL rst_mid_burst got=%b exp=00000000", {s_cyc, s_stb, m1_gnt, m0_gnt, m0_ack, m1_ack, m0_err, m1_err});
      end
      idle_inputs();
      step();
      rst_n = 1;
      step();
      n_vec++;
      if (dut.scnt !== 8'd0 || m1_err !== 1'b0 || m1_ack !== 1'b0) begin
         n_err++; $display("FAIL rst_scnt got scnt=%0d err1=%b ack1=%b exp 0 0 0", dut.scnt, m1_err, m1_ack);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst_n = 0;
      test_reset();
      test_single_read();
      test_starvation();
      test_burst_hold();
      test_timeout();
      test_ack_vs_timeout();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
